// File: rtl/ibuf_nw.sv
// Parametrised instruction buffer between fetch and decode: circular FIFO of
// fetched-instruction records with multi-lane write/read, exception truncation and interrupt marking.
module ibuf_nw #(
  parameter int DEPTH    = 8,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 2,
  parameter int SKID     = 2,
  parameter int EXCP_W   = 6,
  parameter int EXCP_INT = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          interrupt,
  input  logic [$clog2(IN_W+1)-1:0]     i_size,
  output logic                          i_ready,
  input  logic [IN_W*32-1:0]            i_pc,
  input  logic [IN_W*32-1:0]            i_inst,
  input  logic [IN_W-1:0]               i_pred_taken,
  input  logic [IN_W*32-1:0]            i_pred_target,
  input  logic [IN_W-1:0]               i_have_excp,
  input  logic [IN_W*EXCP_W-1:0]        i_excp_type,
  input  logic [$clog2(OUT_W+1)-1:0]    o_size,
  output logic [OUT_W-1:0]              o_valid,
  output logic [OUT_W*32-1:0]           o_pc,
  output logic [OUT_W*32-1:0]           o_inst,
  output logic [OUT_W-1:0]              o_pred_taken,
  output logic [OUT_W*32-1:0]           o_pred_target,
  output logic [OUT_W-1:0]              o_have_excp,
  output logic [OUT_W*EXCP_W-1:0]       o_excp_type,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]       pcMem     [DEPTH];
  logic [31:0]       instMem   [DEPTH];
  logic              takenMem  [DEPTH];
  logic [31:0]       targetMem [DEPTH];
  logic              excpMem   [DEPTH];
  logic [EXCP_W-1:0] typeMem   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [PW-1:0] rdIdx [OUT_W];
  logic [PW-1:0] wrIdx [IN_W];
  int            validCnt;
  int            inCnt;
  int            consumed;
  int            space;
  int            written;
  logic          overflow;
  logic          intrActive;
  logic          blocked;

  assign i_ready      = (int'(count_q) + SKID + IN_W) <= DEPTH;
  assign count        = count_q;
  assign err_overflow = err_q;

  // Lanes stop after the first raw-valid excepting entry; an interrupt keeps only lane 0.
  always_comb begin
    o_valid       = '0;
    o_pc          = '0;
    o_inst        = '0;
    o_pred_taken  = '0;
    o_pred_target = '0;
    o_have_excp   = '0;
    o_excp_type   = '0;
    validCnt      = 0;
    blocked       = 1'b0;
    intrActive    = interrupt && (count_q != '0);
    for (int k = 0; k < OUT_W; k++) begin
      rdIdx[k] = head_q + PW'(k);
      o_pc[32*k +: 32]                = pcMem[rdIdx[k]];
      o_inst[32*k +: 32]              = instMem[rdIdx[k]];
      o_pred_taken[k]                 = takenMem[rdIdx[k]];
      o_pred_target[32*k +: 32]       = targetMem[rdIdx[k]];
      o_have_excp[k]                  = excpMem[rdIdx[k]];
      o_excp_type[EXCP_W*k +: EXCP_W] = typeMem[rdIdx[k]];
      if ((int'(count_q) > k) && !blocked && !(intrActive && (k != 0))) begin
        o_valid[k] = 1'b1;
        validCnt++;
      end
      if ((int'(count_q) > k) && excpMem[rdIdx[k]]) begin
        blocked = 1'b1;
      end
    end
    if (intrActive) begin
      o_have_excp[0]            = 1'b1;
      o_excp_type[EXCP_W-1:0]   = EXCP_W'(EXCP_INT);
    end
  end

  // Reads free space before writes claim it, so a full buffer can accept while draining.
  always_comb begin
    inCnt    = (int'(i_size) > IN_W) ? IN_W : int'(i_size);
    consumed = (int'(o_size) > validCnt) ? validCnt : int'(o_size);
    space    = DEPTH - (int'(count_q) - consumed);
    overflow = inCnt > space;
    written  = overflow ? space : inCnt;
    head_d   = head_q + PW'(consumed);
    tail_d   = tail_q + PW'(written);
    count_d  = CW'(int'(count_q) - consumed + written);
    err_d    = err_q | overflow;
    if (reset || flush) begin
      written = 0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
    for (int k = 0; k < IN_W; k++) begin
      wrIdx[k] = tail_q + PW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is never cleared; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_W; k++) begin
      if (k < written) begin
        pcMem[wrIdx[k]]     <= i_pc[32*k +: 32];
        instMem[wrIdx[k]]   <= i_inst[32*k +: 32];
        takenMem[wrIdx[k]]  <= i_pred_taken[k];
        targetMem[wrIdx[k]] <= i_pred_target[32*k +: 32];
        excpMem[wrIdx[k]]   <= i_have_excp[k];
        typeMem[wrIdx[k]]   <= i_excp_type[EXCP_W*k +: EXCP_W];
      end
    end
  end

endmodule

// File: tb/tb_ibuf_nw.sv
// Scoreboard bench for ibuf_nw: a queue-based reference model predicts each cycle's outputs,
// and an independent monitor compares them against the DUT.
module tb_ibuf_nw;

  localparam int DEPTH    = 8;
  localparam int IN_W     = 2;
  localparam int OUT_W    = 2;
  localparam int SKID     = 2;
  localparam int EXCP_W   = 6;
  localparam int EXCP_INT = 0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              taken;
    logic [31:0]       target;
    logic              excp;
    logic [EXCP_W-1:0] etype;
  } ent_t;

  typedef struct {
    logic [OUT_W-1:0]        valid;
    int                      cnt;
    logic                    rdy;
    logic                    err;
    logic [OUT_W*32-1:0]     pc;
    logic [OUT_W*32-1:0]     inst;
    logic [OUT_W-1:0]        taken;
    logic [OUT_W*32-1:0]     target;
    logic [OUT_W-1:0]        excp;
    logic [OUT_W*EXCP_W-1:0] etype;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset, flush, interrupt;
  logic [$clog2(IN_W+1)-1:0]  i_size;
  logic                       i_ready;
  logic [IN_W*32-1:0]         i_pc, i_inst, i_pred_target;
  logic [IN_W-1:0]            i_pred_taken, i_have_excp;
  logic [IN_W*EXCP_W-1:0]     i_excp_type;
  logic [$clog2(OUT_W+1)-1:0] o_size;
  logic [OUT_W-1:0]           o_valid, o_pred_taken, o_have_excp;
  logic [OUT_W*32-1:0]        o_pc, o_inst, o_pred_target;
  logic [OUT_W*EXCP_W-1:0]    o_excp_type;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       err_overflow;

  ent_t  mq[$];
  exp_t  expQ[$];
  logic  errM = 1'b0;
  int    checks = 0;
  int    errors = 0;
  logic [31:0] pcNext;

  logic [31:0]       inPc     [IN_W];
  logic [31:0]       inInst   [IN_W];
  logic              inTaken  [IN_W];
  logic [31:0]       inTarget [IN_W];
  logic              inExcp   [IN_W];
  logic [EXCP_W-1:0] inType   [IN_W];

  ibuf_nw #(
    .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .SKID(SKID),
    .EXCP_W(EXCP_W), .EXCP_INT(EXCP_INT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .interrupt(interrupt),
    .i_size(i_size), .i_ready(i_ready), .i_pc(i_pc), .i_inst(i_inst),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .i_have_excp(i_have_excp), .i_excp_type(i_excp_type),
    .o_size(o_size), .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .o_have_excp(o_have_excp), .o_excp_type(o_excp_type),
    .count(count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic setLane(input int k, input logic [31:0] pc, input logic excp, input logic [EXCP_W-1:0] et);
    inPc[k]     = pc;
    inInst[k]   = $urandom;
    inTaken[k]  = 1'($urandom_range(0, 1));
    inTarget[k] = $urandom;
    inExcp[k]   = excp;
    inType[k]   = et;
  endtask

  task automatic seqLanes(input int n);
    for (int k = 0; k < n; k++) begin
      setLane(k, pcNext, 1'b0, '0);
      pcNext += 32'd4;
    end
  endtask

  // Drive one cycle, predict the visible outputs from the model, then advance the model.
  task automatic applyStimulus(input logic rstIn, input logic flushIn, input logic intrIn,
                               input int iSz, input int oSz);
    exp_t e;
    ent_t x;
    int   n;
    int   cons;
    int   isz;
    @(negedge clk);
    reset     = rstIn;
    flush     = flushIn;
    interrupt = intrIn;
    i_size    = 2'(iSz);
    o_size    = 2'(oSz);
    for (int k = 0; k < IN_W; k++) begin
      i_pc[32*k +: 32]                = inPc[k];
      i_inst[32*k +: 32]              = inInst[k];
      i_pred_taken[k]                 = inTaken[k];
      i_pred_target[32*k +: 32]       = inTarget[k];
      i_have_excp[k]                  = inExcp[k];
      i_excp_type[EXCP_W*k +: EXCP_W] = inType[k];
    end
    #1;
    n = 0;
    for (int k = 0; k < OUT_W && k < mq.size(); k++) begin
      n++;
      if (mq[k].excp) break;
    end
    if (intrIn && mq.size() > 0) n = 1;
    e.valid  = '0;
    e.pc     = '0;
    e.inst   = '0;
    e.taken  = '0;
    e.target = '0;
    e.excp   = '0;
    e.etype  = '0;
    e.cnt    = mq.size();
    e.rdy    = (mq.size() + SKID + IN_W) <= DEPTH;
    e.err    = errM;
    for (int k = 0; k < n; k++) begin
      e.valid[k]                  = 1'b1;
      e.pc[32*k +: 32]            = mq[k].pc;
      e.inst[32*k +: 32]          = mq[k].inst;
      e.taken[k]                  = mq[k].taken;
      e.target[32*k +: 32]        = mq[k].target;
      e.excp[k]                   = mq[k].excp;
      e.etype[EXCP_W*k +: EXCP_W] = mq[k].etype;
    end
    if (intrIn && n > 0) begin
      e.excp[0]            = 1'b1;
      e.etype[EXCP_W-1:0]  = EXCP_W'(EXCP_INT);
    end
    expQ.push_back(e);
    @(posedge clk);
    if (rstIn || flushIn) begin
      mq.delete();
      errM = 1'b0;
    end else begin
      cons = (oSz < n) ? oSz : n;
      repeat (cons) void'(mq.pop_front());
      isz = (iSz > IN_W) ? IN_W : iSz;
      for (int k = 0; k < isz; k++) begin
        x.pc     = inPc[k];
        x.inst   = inInst[k];
        x.taken  = inTaken[k];
        x.target = inTarget[k];
        x.excp   = inExcp[k];
        x.etype  = inType[k];
        if (mq.size() < DEPTH) mq.push_back(x);
        else errM = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("o_valid", 64'(o_valid), 64'(e.valid));
    cmp("count", 64'(count), 64'(e.cnt));
    cmp("i_ready", 64'(i_ready), 64'(e.rdy));
    cmp("err_overflow", 64'(err_overflow), 64'(e.err));
    for (int k = 0; k < OUT_W; k++) begin
      if (e.valid[k]) begin
        cmp($sformatf("lane%0d pc", k), 64'(o_pc[32*k +: 32]), 64'(e.pc[32*k +: 32]));
        cmp($sformatf("lane%0d inst", k), 64'(o_inst[32*k +: 32]), 64'(e.inst[32*k +: 32]));
        cmp($sformatf("lane%0d taken", k), 64'(o_pred_taken[k]), 64'(e.taken[k]));
        cmp($sformatf("lane%0d target", k), 64'(o_pred_target[32*k +: 32]), 64'(e.target[32*k +: 32]));
        cmp($sformatf("lane%0d excp", k), 64'(o_have_excp[k]), 64'(e.excp[k]));
        cmp($sformatf("lane%0d etype", k), 64'(o_excp_type[EXCP_W*k +: EXCP_W]),
            64'(e.etype[EXCP_W*k +: EXCP_W]));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; interrupt = 1'b0;
    i_size = '0; o_size = '0;
    i_pc = '0; i_inst = '0; i_pred_target = '0;
    i_pred_taken = '0; i_have_excp = '0; i_excp_type = '0;
    pcNext = 32'h1c00_0000;
    seqLanes(IN_W);
    repeat (2) @(posedge clk);

    // Fill then drain
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    pcNext = 32'h1c00_0000;
    repeat (4) begin seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0); end
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);

    // Wrap-around with three entries resident
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    seqLanes(1); applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    repeat (12) begin seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 2); end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Exception truncation
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    setLane(0, 32'h100, 1'b0, 6'd0); setLane(1, 32'h104, 1'b1, 6'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    setLane(0, 32'h108, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);
    setLane(0, 32'h200, 1'b1, 6'd7); setLane(1, 32'h204, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1);

    // Interrupt isolates lane 0
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    seqLanes(1); applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Flush colliding with read and write
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    seqLanes(1); applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b1, 1'b0, 2, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Overflow, sticky error, and size clamping
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (3) begin seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0); end
    seqLanes(1); applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 2, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    seqLanes(1); applyStimulus(1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);
    seqLanes(2); applyStimulus(1'b0, 1'b0, 1'b0, 3, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Randomised traffic
    repeat (500) begin
      for (int k = 0; k < IN_W; k++)
        setLane(k, $urandom, 1'($urandom_range(0, 99) < 15), EXCP_W'($urandom));
      applyStimulus(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 4),
                    1'($urandom_range(0, 99) < 10), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    #5;
    cmp("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibuf_nw.md
Name: ibuf_nw

Overview:
- Parametrised successor of the 2-in/2-out instruction buffer between fetch and decode.
- Circular FIFO of fetched-instruction records, with a configurable number of entries, input lanes and output lanes.
- New over the previous generation:
  - per-lane exception input on every lane;
  - output truncation after an excepting entry;
  - interrupt isolation to lane 0;
  - a configurable skid reserve in the ready calculation;
  - a sticky overflow error flag.

Parameters:
- DEPTH, 8: entry count; power of two, >= 2*IN_W.
- IN_W, 2: input lanes per cycle.
- OUT_W, 2: output lanes per cycle.
- SKID, 2: entries reserved for fetch requests already in flight.
- EXCP_W, 6: width of the exception-type code.
- EXCP_INT, 0: exception code reported for an interrupt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all contents (pipeline redirect)
- interrupt  in  1  pending interrupt, level
- i_size  in  $clog2(IN_W+1)  number of input lanes written this cycle (lanes 0..i_size-1)
- i_ready  out  1  fetch may issue; upstream must not exceed free space
- i_pc  in  IN_W*32  per-lane PC; lane k occupies bits [32k+31:32k]
- i_inst  in  IN_W*32  per-lane instruction
- i_pred_taken  in  IN_W  per-lane predicted taken
- i_pred_target  in  IN_W*32  per-lane predicted target
- i_have_excp  in  IN_W  per-lane exception flag
- i_excp_type  in  IN_W*EXCP_W  per-lane exception code
- o_size  in  $clog2(OUT_W+1)  entries consumed this cycle (lanes 0..o_size-1)
- o_valid  out  OUT_W  thermometer code; lane k valid implies lanes 0..k-1 valid
- o_pc, o_inst, o_pred_taken, o_pred_target, o_have_excp, o_excp_type  out  OUT_W-lane versions of the input fields
- count  out  $clog2(DEPTH+1)  current occupancy
- err_overflow  out  1  sticky: a write was dropped

Behaviour:
- Storage: DEPTH entries, each holding pc, inst, pred_taken, pred_target, have_excp and excp_type. Pointers head and tail are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- Reset and flush (reset has priority, flush is equivalent): head=tail=count=0 and o_valid=0. err_overflow clears to 0. Inputs in that cycle are ignored; entry payloads are not cleared.
- i_ready is combinational: (count + SKID + IN_W) <= DEPTH. With the defaults this gives count <= 4.
- Write: lanes 0..i_size-1 are written to tail, tail+1, ... (mod DEPTH). i_size > IN_W is clamped to IN_W.
- Read: o_size is clamped to the current o_valid population count. This cycle, head advances by the clamped o_size.
- Next count = count + written - consumed. Simultaneous read and write is allowed, including at full and empty.
- Overflow: if count - consumed + i_size > DEPTH, only the lanes that fit are written, in lane order. Excess lanes are dropped and err_overflow is set until reset or flush.
- Output lanes are combinational from head+k:
  - Raw valid for lane k is count > k.
  - Truncation: if a lane j < k that is raw-valid has have_excp=1, lane k is not valid. An excepting entry is always the last valid lane.
  - Interrupt: when interrupt=1 and count >= 1, lane 0 shows have_excp=1 and excp_type=EXCP_INT, and lanes 1.. are invalid. The stored entry is unchanged.
- Invalid lanes drive don't-care payload. The bench checks payload only where o_valid is set.
- Latency: an entry written in cycle N is visible at the outputs in cycle N+1. There is no bypass.
- Ordering: strict FIFO across wrap-around. Output lanes are in program order.

Test Plan:
- Fill then drain: reset, write PCs 0x1c000000..0x1c00001c two per cycle over 4 cycles.
  - i_ready drops when count reaches 6.
  - Drain with o_size=2 → PCs appear in order, and count returns to 0.
- Wrap-around: keep 3 entries in steady state, writing 2 and reading 2 per cycle for 12 cycles → PC sequence continuous across head=7→0, and count stays 3.
- Exception truncation: write lane 0 PC 0x100 with have_excp=0 and lane 1 PC 0x104 with have_excp=1 and excp_type=5, then a third entry 0x108.
  - With OUT_W=2: o_valid=2'b11 with 0x104 excepting.
  - After consuming 2, 0x108 appears alone in lane 0.
  - Then place the excepting entry in lane 0 and an entry behind it → o_valid=2'b01.
- Interrupt: count=3 with interrupt=1 → o_valid=2'b01, o_have_excp[0]=1, o_excp_type[0]=EXCP_INT. Deassert interrupt → original lane-0 fields return.
- Flush collision: flush asserted while i_size=2 and o_size=2 with count=5 → next cycle count=0, o_valid=0, and no flushed-cycle entry is visible.
- Overflow and clamping: with count=7, force i_size=2 and o_size=0 → one entry written, count=8, err_overflow=1 until reset. With count=1, o_size=2 → only 1 consumed and count=0.
